div6abmod47_seq: RTL and testbench



---
 rtl/div6abmod47_seq.sv | 151 +++++++++++++++
 tb/tb_div6abmod47_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div6abmod47_seq.sv
// Sequential GF(47) divider: R = A * B^-1 mod 47, with B^-1 = B^45 found by square-and-multiply
// on one shared mod-47 multiplier, followed by a final multiply by A.
module div6abmod47_seq #(
    parameter int P   = 47,
    parameter int EXP = 45
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:1] A,
    input  logic [6:1] B,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [6:1] R
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [5:0] P6      = 6'(P);
    localparam logic [4:0] FOLD    = 5'(64 - P);
    localparam logic [7:0] P_X1    = 8'(P);
    localparam logic [7:0] P_X2    = 8'(2 * P);
    localparam logic [2:0] LAST_OP = 3'd7;

    // Bit s is set when schedule step s multiplies by b_r instead of squaring.
    function automatic logic [7:0] sched_mask(input logic [4:0] e);
        logic [7:0] m;
        int         s;
        m = '0;
        s = 0;
        for (int i = 4; i >= 0; i--) begin
            s = s + 1;
            if (e[i]) begin
                m[s[2:0]] = 1'b1;
                s = s + 1;
            end
        end
        return m;
    endfunction

    localparam logic [7:0] MUL_MASK = sched_mask(5'(EXP));

    function automatic logic [5:0] red(input logic [5:0] x);
        return (x >= P6) ? x - P6 : x;
    endfunction

    // 64 = 17 mod 47, so each fold replaces the bits above 2^6 with hi*17; three folds leave < 2*94.
    function automatic logic [5:0] mulmod(input logic [5:0] a, input logic [5:0] b);
        logic [11:0] p;
        logic [10:0] t1;
        logic [8:0]  t2;
        logic [7:0]  t3;
        p  = {6'd0, a} * {6'd0, b};
        t1 = {5'd0, p[11:6]} * 11'(FOLD) + {5'd0, p[5:0]};
        t2 = {4'd0, t1[10:6]} * 9'(FOLD) + {3'd0, t1[5:0]};
        t3 = {5'd0, t2[8:6]} * 8'(FOLD) + {2'd0, t2[5:0]};
        if (t3 >= P_X2) t3 = t3 - P_X2;
        if (t3 >= P_X1) t3 = t3 - P_X1;
        return t3[5:0];
    endfunction

    state_t     state_q, state_d;
    logic [5:0] acc_q, acc_d;
    logic [5:0] a_r_q, a_r_d;
    logic [5:0] b_r_q, b_r_d;
    logic [2:0] step_q, step_d;
    logic [5:0] r_q, r_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic [5:0] mul_y;
    logic [5:0] mul_r;
    logic [5:0] b_in;

    assign ready = (state_q == IDLE) && !done_q;
    assign done  = done_q;
    assign err   = err_q;
    assign R     = r_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_r_d   = a_r_q;
        b_r_d   = b_r_q;
        step_d  = step_q;
        r_d     = r_q;
        err_d   = err_q;
        done_d  = 1'b0;
        b_in    = red(B);

        // Shared multiplier: acc times acc, b_r or a_r depending on state and step.
        if (state_q == FIN) begin
            mul_y = a_r_q;
        end else if (MUL_MASK[step_q]) begin
            mul_y = b_r_q;
        end else begin
            mul_y = acc_q;
        end
        mul_r = mulmod(acc_q, mul_y);

        case (state_q)
            IDLE: begin
                if (start && ready) begin
                    a_r_d   = red(A);
                    b_r_d   = b_in;
                    acc_d   = b_in;
                    step_d  = 3'd0;
                    state_d = (b_in == 6'd0) ? FIN : RUN;
                end
            end
            RUN: begin
                acc_d  = mul_r;
                step_d = step_q + 3'd1;
                if (step_q == LAST_OP) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (b_r_q == 6'd0) begin
                    r_d   = 6'd0;
                    err_d = 1'b1;
                end else begin
                    r_d   = mul_r;
                    err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_r_q   <= '0;
            b_r_q   <= '0;
            step_q  <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_r_q   <= a_r_d;
            b_r_q   <= b_r_d;
            step_q  <= step_d;
            r_q     <= r_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_div6abmod47_seq.sv
// Directed-vector bench for div6abmod47_seq: table of hand-computed quotients, reset and
// abort sequences, and a back-to-back exhaustive sweep checked by R*red(B) = red(A) mod 47.
module tb_div6abmod47_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:1] A;
    logic [6:1] B;
    logic       ready;
    logic       done;
    logic       err;
    logic [6:1] R;

    int nvec = 0;
    int nmis = 0;

    div6abmod47_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .ready(ready),
        .done (done),
        .err  (err),
        .R    (R)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int r;
        int e;
        int lat;
    } vec_t;

    vec_t tbl[12];

    function automatic int red(input int x);
        return (x >= 47) ? x - 47 : x;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Starts one op at the next edge and waits (bounded) for done; returns latency in cycles.
    task automatic run_op(input int a, input int b, output int r, output int e,
                          output int lat, output int busy_bad);
        int n;
        n = 0;
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        A = 6'(a);
        B = 6'(b);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = 6'($urandom);
        B = 6'($urandom);
        lat = 1;
        busy_bad = 0;
        while (!done && lat < 30) begin
            if (ready) busy_bad = 1;
            @(negedge clk);
            lat++;
        end
        if (ready) busy_bad = 1;
        r = int'(R);
        e = int'(err);
    endtask

    initial begin
        int r, e, lat, bad;
        tbl[0]  = '{a: 1,  b: 2,  r: 24, e: 0, lat: 10};
        tbl[1]  = '{a: 5,  b: 3,  r: 33, e: 0, lat: 10};
        tbl[2]  = '{a: 10, b: 46, r: 37, e: 0, lat: 10};
        tbl[3]  = '{a: 63, b: 1,  r: 16, e: 0, lat: 10};
        tbl[4]  = '{a: 0,  b: 5,  r: 0,  e: 0, lat: 10};
        tbl[5]  = '{a: 7,  b: 47, r: 0,  e: 1, lat: 2};
        tbl[6]  = '{a: 20, b: 20, r: 1,  e: 0, lat: 10};
        tbl[7]  = '{a: 0,  b: 0,  r: 0,  e: 1, lat: 2};
        tbl[8]  = '{a: 3,  b: 5,  r: 10, e: 0, lat: 10};
        tbl[9]  = '{a: 50, b: 1,  r: 3,  e: 0, lat: 10};
        tbl[10] = '{a: 63, b: 63, r: 1,  e: 0, lat: 10};
        tbl[11] = '{a: 46, b: 2,  r: 23, e: 0, lat: 10};

        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", int'(ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_R", int'(R), 0);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].a, tbl[i].b, r, e, lat, bad);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_R", i), r, tbl[i].r);
            chk($sformatf("vec%0d_err", i), e, tbl[i].e);
            chk($sformatf("vec%0d_ready_low_while_busy", i), bad, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_single", i), int'(done), 0);
            chk($sformatf("vec%0d_R_held", i), int'(R), tbl[i].r);
        end

        // Abort: reset asserted in cycle 5 of an op (R currently holds 23).
        A = 6'd1;
        B = 6'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", int'(done), 0);
        chk("abort_R", int'(R), 0);
        chk("abort_err", int'(err), 0);
        @(negedge clk);
        chk("abort_ready", int'(ready), 1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) bad = 1;
            @(negedge clk);
        end
        chk("abort_no_done", bad, 0);
        run_op(5, 3, r, e, lat, bad);
        chk("post_abort_R", r, 33);
        chk("post_abort_latency", lat, 10);

        // Back-to-back sweep with start held high and junk on A/B while busy.
        begin
            int idx, cap_a, cap_b, last_cap, exp_space, cyc, ndone;
            logic prev_done;
            idx = 0;
            cap_a = 0;
            cap_b = 0;
            last_cap = -1;
            exp_space = 0;
            cyc = 0;
            ndone = 0;
            prev_done = 1'b0;
            while (!ready) @(negedge clk);
            start = 1'b1;
            while (cyc < 60000) begin
                if (done) begin
                    ndone++;
                    if (red(cap_b) == 0) begin
                        chk("sweep_err_flag", int'(err), 1);
                        chk("sweep_err_R", int'(R), 0);
                    end else begin
                        chk("sweep_err_clear", int'(err), 0);
                        chk($sformatf("sweep_R_A%0d_B%0d", cap_a, cap_b),
                            (int'(R) * red(cap_b)) % 47 + ((R > 6'd46) ? 100 : 0), red(cap_a));
                    end
                    if (prev_done) chk("sweep_done_consecutive", 1, 0);
                end
                if (ready) begin
                    if (last_cap >= 0) chk("sweep_spacing", cyc - last_cap, exp_space);
                    if (idx == 4096) break;
                    cap_a = idx / 64;
                    cap_b = idx % 64;
                    A = 6'(cap_a);
                    B = 6'(cap_b);
                    exp_space = (red(cap_b) == 0) ? 3 : 11;
                    last_cap = cyc;
                    idx++;
                end else begin
                    A = 6'($urandom);
                    B = 6'($urandom);
                end
                prev_done = done;
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            chk("sweep_completed", idx, 4096);
            chk("sweep_done_count", ndone, 4096);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
